alu_core_param: RTL and testbench
=================================

Name: alu_core_param

Overview:
- Parametrised, registered successor of the single-width accumulator ALU. It executes the alu_op instruction set against internal registers A, B, ACC and INDEX.
- Adds data/address width parameters, a valid/ready command handshake, status flags and multi-bit shifts. Shifts run one bit per cycle through a small FSM.
- Sits between the instruction decoder (command source) and the RAM/DMA datapath. It consumes INDEX for indexed addressing and drives out_data on op_oeacc.

Parameters:
- DATA_W, 8, width of A, B, ACC, data_in, out_data.
- ADDR_W, 8, width of INDEX (log2 of RAM_DEPTH = 256).
- SHAMT_W, 3, width of shift amount taken from B[SHAMT_W-1:0].

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  5  alu_op encoding: nop=0, lda=1, ldb=2, ldacc=3, ldid=4, mvacc2id=5, mvacc2a=6, mvacc2b=7, add=8, sub=9, shiftl=10, shiftr=11, and=12, or=13, xor=14, cmpe=15, cmpl=16, cmpg=17, ascii2bin=18, bin2ascii=19, oeacc=20.
- data_in  in  DATA_W  operand for external loads.
- acc  out  DATA_W  ACC register.
- index  out  ADDR_W  INDEX register.
- flag_z  out  1  last ACC write was zero.
- flag_c  out  1  carry (add) / borrow (sub).
- flag_cmp  out  1  result of last compare.
- flag_err  out  1  last conversion or opcode was illegal.
- out_data  out  DATA_W  ACC copy driven by oeacc.
- out_valid  out  1  one-cycle pulse with out_data.
- done  out  1  one-cycle pulse when a command retires.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset: A, B, ACC, INDEX, out_data = 0; all flags 0; out_valid = 0; done = 0; busy = 0; state = IDLE; cmd_ready = 1. Reset mid-shift aborts the shift; no done pulse.
- Handshake:
  - Accept when cmd_valid & cmd_ready.
  - cmd_ready = (state == IDLE).
  - Commands presented while not ready are ignored, not queued.
- FSM states: IDLE, SHIFT.
  - Non-shift op in IDLE: registers and flags update at the accepting edge; done pulses the next cycle; FSM stays in IDLE. Throughput is 1 op/cycle.
  - Shift with amount n = B[SHAMT_W-1:0]:
    - n = 0: behaves like a single-cycle op; ACC = A.
    - n > 0: ACC = A at accept, state = SHIFT, counter = n-1; each SHIFT cycle shifts ACC by 1 bit (zero-fill).
    - Counter 0 completes the shift; the next cycle returns to IDLE with done pulsed. Total done latency = n cycles after accept.
  - flag_c holds the last bit shifted out.
- Loads:
  - lda/ldb/ldacc: A/B/ACC = data_in.
  - ldid: INDEX = data_in[ADDR_W-1:0] (zero-extend if ADDR_W > DATA_W).
  - mvacc2a/mvacc2b: copy ACC into A/B.
  - mvacc2id: INDEX = ACC, truncated or zero-extended.
- Arithmetic:
  - add: {flag_c, ACC} = A + B in DATA_W+1 bits.
  - sub: ACC = A − B mod 2^DATA_W; flag_c = (A < B) unsigned.
- Logic: and/or/xor: ACC = A op B; flag_c unchanged.
- Compare (unsigned): cmpe/cmpl/cmpg set flag_cmp = (A==B)/(A<B)/(A>B). ACC, flag_z and flag_c are unchanged.
- flag_z = (new ACC == 0) on every ACC write, including ldacc and shift completion.
- ascii2bin on A[7:0]:
  - 0x30–0x39 → A − 0x30.
  - 0x41–0x46 → A − 0x37.
  - 0x61–0x66 → A − 0x57.
  - Otherwise ACC = 0, flag_err = 1.
  - Result is zero-extended into ACC.
- bin2ascii:
  - A < 16 → ACC = uppercase hex ASCII of A.
  - Otherwise ACC = 0x3F ('?'), flag_err = 1.
- flag_err is cleared by any accepted legal op other than a failing conversion.
- oeacc: out_data = ACC, out_valid pulses the next cycle; out_data holds afterwards.
- nop: done pulses, no state change. Opcodes 21–31: treated as nop, flag_err = 1.

Test Plan:
- Reset then lda 0x0F, ldb 0xF1, add → ACC = 0x00, flag_c = 1, flag_z = 1, done one cycle after add accept.
- lda 0x03, ldb 0x05, sub → ACC = 0xFE, flag_c = 1; then cmpl → flag_cmp = 1, ACC still 0xFE.
- lda 0x81, ldb 0x03, shiftl → cmd_ready low for 3 cycles, ACC = 0x08, flag_c = 0, done 3 cycles after accept. Assert rst during a repeat of the same shift → no done, all registers 0.
- Conversions:
  - lda 0x41, ascii2bin → ACC = 0x0A, flag_err = 0.
  - lda 0x47, ascii2bin → ACC = 0, flag_err = 1.
  - lda 0x0C, bin2ascii → ACC = 0x43.
- ldacc 0x5A, mvacc2id, oeacc → index = 0x5A; out_valid pulses once with out_data = 0x5A. Back-to-back commands accepted every cycle with no bubbles.
- cmd_op = 25 → flag_err = 1, no register change, done pulses.

Source files
------------

// File: rtl/alu_core_param.sv
// alu_core_param: registered accumulator ALU with valid/ready commands, status flags and bit-serial shifts
module alu_core_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int SHAMT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_op,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] index,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_cmp,
  output logic              flag_err,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              done,
  output logic              busy
);
  localparam logic [4:0] NOP = 5'd0, LDA = 5'd1, LDB = 5'd2, LDACC = 5'd3, LDID = 5'd4,
    MV2ID = 5'd5, MV2A = 5'd6, MV2B = 5'd7, ADD = 5'd8, SUB = 5'd9, SHL = 5'd10,
    SHR = 5'd11, AND_ = 5'd12, OR_ = 5'd13, XOR_ = 5'd14, CMPE = 5'd15, CMPL = 5'd16,
    CMPG = 5'd17, A2B = 5'd18, B2A = 5'd19, OEACC = 5'd20;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [DATA_W-1:0] a, b, acc_nxt;
  logic [SHAMT_W-1:0] cnt, n;
  logic dir, fire, acc_we, c_we, c_nxt, is_shift;
  logic [DATA_W:0] sum;
  logic [7:0] a8, a2b, b2a;
  logic [3:0] nib;
  logic dig, up, lo, a2b_ok, b2a_ok;
  assign cmd_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign fire      = cmd_valid & cmd_ready;
  assign n         = b[SHAMT_W-1:0];
  assign is_shift  = cmd_op == SHL || cmd_op == SHR;
  assign sum       = {1'b0, a} + {1'b0, b};
  assign a8        = 8'(a);
  assign dig       = a8 >= 8'h30 && a8 <= 8'h39;
  assign up        = a8 >= 8'h41 && a8 <= 8'h46;
  assign lo        = a8 >= 8'h61 && a8 <= 8'h66;
  assign a2b_ok    = dig | up | lo;
  assign a2b       = dig ? a8 - 8'h30 : up ? a8 - 8'h37 : lo ? a8 - 8'h57 : 8'h00;
  assign nib       = a[3:0];
  assign b2a_ok    = (a >> 4) == '0;
  assign b2a       = {4'h0, nib} + (nib < 4'd10 ? 8'h30 : 8'h37);
  // ACC and carry writers are shared by the shift engine and single-cycle ops
  always_comb begin
    acc_we  = 1'b0;
    acc_nxt = acc;
    c_we    = 1'b0;
    c_nxt   = flag_c;
    if (state == SHIFT) begin
      acc_we  = 1'b1;
      acc_nxt = dir ? acc >> 1 : acc << 1;
      c_we    = 1'b1;
      c_nxt   = dir ? acc[0] : acc[DATA_W-1];
    end else if (fire) begin
      case (cmd_op)
        LDACC:    begin acc_we = 1'b1; acc_nxt = data_in; end
        ADD:      begin acc_we = 1'b1; acc_nxt = sum[DATA_W-1:0]; c_we = 1'b1; c_nxt = sum[DATA_W]; end
        SUB:      begin acc_we = 1'b1; acc_nxt = a - b; c_we = 1'b1; c_nxt = a < b; end
        SHL, SHR: begin acc_we = 1'b1; acc_nxt = a; end
        AND_:     begin acc_we = 1'b1; acc_nxt = a & b; end
        OR_:      begin acc_we = 1'b1; acc_nxt = a | b; end
        XOR_:     begin acc_we = 1'b1; acc_nxt = a ^ b; end
        A2B:      begin acc_we = 1'b1; acc_nxt = DATA_W'(a2b); end
        B2A:      begin acc_we = 1'b1; acc_nxt = b2a_ok ? DATA_W'(b2a) : DATA_W'(8'h3F); end
        default:  ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      acc       <= '0;
      index     <= '0;
      out_data  <= '0;
      cnt       <= '0;
      dir       <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_cmp  <= 1'b0;
      flag_err  <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      out_valid <= 1'b0;
      if (acc_we) begin
        acc    <= acc_nxt;
        flag_z <= acc_nxt == '0;
      end
      if (c_we) flag_c <= c_nxt;
      if (state == SHIFT) begin
        if (cnt == '0) begin
          state <= IDLE;
          done  <= 1'b1;
        end else cnt <= cnt - 1'b1;
      end else if (fire) begin
        done     <= !(is_shift && n != '0);
        flag_err <= cmd_op > OEACC || (cmd_op == A2B && !a2b_ok) || (cmd_op == B2A && !b2a_ok);
        case (cmd_op)
          LDA:      a <= data_in;
          LDB:      b <= data_in;
          LDID:     index <= ADDR_W'(data_in);
          MV2ID:    index <= ADDR_W'(acc);
          MV2A:     a <= acc;
          MV2B:     b <= acc;
          CMPE:     flag_cmp <= a == b;
          CMPL:     flag_cmp <= a < b;
          CMPG:     flag_cmp <= a > b;
          OEACC:    begin out_data <= acc; out_valid <= 1'b1; end
          SHL, SHR: if (n != '0) begin
            state <= SHIFT;
            cnt   <= n - 1'b1;
            dir   <= cmd_op == SHR;
          end
          default:  ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alu_core_param.sv
// tb_alu_core_param: randomized scoreboard bench with a behavioural model of the ALU
module tb_alu_core_param;
  localparam int DW = 8, AW = 8, SW = 3;
  typedef logic [28:0] exp_t;
  logic clk = 0, rst = 1, cmd_valid = 0;
  logic cmd_ready;
  logic [4:0] cmd_op = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] acc, out_data;
  logic [AW-1:0] index;
  logic flag_z, flag_c, flag_cmp, flag_err, out_valid, done, busy;
  alu_core_param #(.DATA_W(DW), .ADDR_W(AW), .SHAMT_W(SW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .data_in(data_in), .acc(acc), .index(index), .flag_z(flag_z), .flag_c(flag_c),
    .flag_cmp(flag_cmp), .flag_err(flag_err), .out_data(out_data), .out_valid(out_valid),
    .done(done), .busy(busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  exp_t q[$];
  int qc[$];
  int passed = 0, total = 0;
  bit mon_on = 0;
  int m_a, m_b, m_acc, m_idx, m_od;
  bit m_z, m_c, m_cmp, m_err;
  string hx = "0123456789ABCDEF";
  string hl = "0123456789abcdef";
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask
  task automatic model_reset();
    m_a = 0; m_b = 0; m_acc = 0; m_idx = 0; m_od = 0;
    m_z = 0; m_c = 0; m_cmp = 0; m_err = 0;
  endtask
  // Reference semantics from the instruction-set description, one retirement at a time
  task automatic model(input int op, input int d, output int lat, output bit ov);
    bit accw = 0, err = 0;
    int n = m_b % 8;
    lat = 0; ov = 0;
    case (op)
      0: ;
      1: m_a = d;
      2: m_b = d;
      3: begin m_acc = d; accw = 1; end
      4: m_idx = d;
      5: m_idx = m_acc;
      6: m_a = m_acc;
      7: m_b = m_acc;
      8: begin m_acc = (m_a + m_b) % 256; m_c = (m_a + m_b) > 255; accw = 1; end
      9: begin m_acc = (m_a - m_b + 256) % 256; m_c = m_a < m_b; accw = 1; end
      10: begin
        accw = 1; lat = n;
        m_acc = (m_a * (1 << n)) % 256;
        if (n > 0) m_c = ((m_a >> (8 - n)) & 1) != 0;
      end
      11: begin
        accw = 1; lat = n;
        m_acc = m_a / (1 << n);
        if (n > 0) m_c = ((m_a >> (n - 1)) & 1) != 0;
      end
      12: begin m_acc = m_a & m_b; accw = 1; end
      13: begin m_acc = m_a | m_b; accw = 1; end
      14: begin m_acc = m_a ^ m_b; accw = 1; end
      15: m_cmp = m_a == m_b;
      16: m_cmp = m_a < m_b;
      17: m_cmp = m_a > m_b;
      18: begin
        accw = 1; err = 1; m_acc = 0;
        for (int i = 0; i < 16; i++)
          if (m_a == int'(hx[i]) || m_a == int'(hl[i])) begin m_acc = i; err = 0; end
      end
      19: begin
        accw = 1;
        if (m_a < 16) m_acc = int'(hx[m_a]);
        else begin m_acc = 'h3F; err = 1; end
      end
      20: begin m_od = m_acc; ov = 1; end
      default: err = 1;
    endcase
    m_err = err;
    if (accw) m_z = m_acc == 0;
  endtask
  task automatic issue(input int op, input int d);
    int t = 0, lat;
    bit ov;
    @(negedge clk);
    cmd_valid = 1; cmd_op = 5'(op); data_in = DW'(d);
    while (!cmd_ready && t < 40) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      total++;
      $display("FAIL accept_timeout: cmd_ready %b expected 1 for op %0d", cmd_ready, op);
      cmd_valid = 0;
      return;
    end
    model(op, d, lat, ov);
    q.push_back({8'(m_acc), 8'(m_idx), m_z, m_c, m_cmp, m_err, ov, 8'(m_od)});
    qc.push_back(cyc + 1 + lat);
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    int ec;
    if (mon_on) begin
      if (done) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL spurious_done: done 1 expected 0 at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          ec = qc.pop_front();
          chk("retire_state", {acc, index, flag_z, flag_c, flag_cmp, flag_err, out_valid, out_data}, e);
          chk("done_cycle", cyc, ec);
        end
      end else if (out_valid) begin
        total++;
        $display("FAIL stray_out_valid: out_valid 1 expected 0 at cycle %0d", cyc);
      end
    end
  end
  initial begin
    int lo, t;
    repeat (3) @(negedge clk);
    chk("rst_regs", {acc, index, out_data}, 0);
    chk("rst_flags", {flag_z, flag_c, flag_cmp, flag_err, out_valid, done, busy}, 0);
    chk("rst_ready", cmd_ready, 1);
    rst = 0; mon_on = 1; model_reset();
    issue(1, 'h0F); issue(2, 'hF1); issue(8, 0);
    issue(1, 'h03); issue(2, 'h05); issue(9, 0); issue(16, 0);
    issue(1, 'h81); issue(2, 'h03); issue(10, 0);
    lo = 0;
    @(negedge clk);
    while (!cmd_ready && lo < 20) begin lo++; @(negedge clk); end
    chk("shift_ready_low", lo, 3);
    issue(10, 0);
    @(negedge clk);
    rst = 1; q.delete(); qc.delete();
    @(negedge clk);
    rst = 0; model_reset();
    chk("midshift_rst_regs", {acc, index, out_data}, 0);
    chk("midshift_rst_state", {busy, cmd_ready, done, flag_z, flag_c, flag_err}, 6'b010000);
    repeat (5) @(negedge clk);
    issue(1, 'h41); issue(18, 0);
    issue(1, 'h47); issue(18, 0);
    issue(1, 'h66); issue(18, 0);
    issue(1, 'h2F); issue(18, 0);
    issue(1, 'h0C); issue(19, 0);
    issue(1, 'h10); issue(19, 0);
    issue(3, 'h5A); issue(5, 0); issue(20, 0);
    issue(25, 0); issue(31, 0); issue(0, 0);
    issue(1, 'hA5); issue(2, 'h08); issue(11, 0); issue(10, 0);
    issue(2, 'h07); issue(11, 0); issue(17, 0); issue(15, 0);
    repeat (400) issue($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 20),
                       $urandom_range(0, 255));
    t = 0;
    while (q.size() != 0 && t < 50) begin @(negedge clk); t++; end
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d retirements outstanding expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
